// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and RAM-side word/byte handshake bundle for the SPI slave front end
interface spi_slave_if #(
  parameter int DATA_W = 10,
  parameter int TX_W   = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [TX_W-1:0]   tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave front end: deserialises MOSI frames into RAM words, serialises the read byte onto MISO
module spi_slave_fsm #(
  parameter int DATA_W = 10,
  parameter int TX_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  // READ_DATA runs through three phases: shift in the word, wait for the RAM, shift out the byte
  localparam logic [1:0] PH_SHIFT = 2'd0;
  localparam logic [1:0] PH_WAIT  = 2'd1;
  localparam logic [1:0] PH_TX    = 2'd2;

  localparam logic [3:0] LAST_RX_BIT = 4'(DATA_W - 1);
  localparam logic [3:0] TX_BITS     = 4'(TX_W);

  logic [2:0]        state_q, state_d;
  logic [1:0]        rd_phase_q, rd_phase_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              rd_flag_q, rd_flag_d;

  logic [DATA_W-1:0] shift_in;
  logic              last_rx_bit;

  assign shift_in    = {shreg_q, bus.MOSI};
  assign last_rx_bit = (bit_cnt_q == LAST_RX_BIT);

  always_comb begin
    state_d    = state_q;
    rd_phase_d = rd_phase_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    rd_flag_d  = rd_flag_q;

    // Deselect wins over everything, including a 10th bit on the same edge
    if (state_q != IDLE && bus.SS_n) begin
      state_d    = IDLE;
      rd_phase_d = PH_SHIFT;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.SS_n) begin
            state_d    = CHK_CMD;
            rd_phase_d = PH_SHIFT;
            bit_cnt_d  = '0;
          end
        end
        CHK_CMD: begin
          if (!bus.MOSI)      state_d = WRITE;
          else if (rd_flag_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        WRITE, READ_ADD: begin
          shreg_d   = shift_in[DATA_W-2:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_rx_bit) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = DONE;
            if (state_q == READ_ADD) rd_flag_d = 1'b1;
          end
        end
        READ_DATA: begin
          case (rd_phase_q)
            PH_SHIFT: begin
              shreg_d   = shift_in[DATA_W-2:0];
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (last_rx_bit) begin
                rx_data_d  = shift_in;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                rd_phase_d = PH_WAIT;
              end
            end
            PH_WAIT: begin
              if (bus.tx_valid) begin
                miso_d     = bus.tx_data[TX_W-1];
                tx_sh_d    = {bus.tx_data[TX_W-2:0], 1'b0};
                bit_cnt_d  = 4'd1;
                rd_phase_d = PH_TX;
              end
            end
            default: begin
              if (bit_cnt_q == TX_BITS) begin
                miso_d     = 1'b0;
                rd_flag_d  = 1'b0;
                bit_cnt_d  = '0;
                rd_phase_d = PH_SHIFT;
                state_d    = DONE;
              end else begin
                miso_d    = tx_sh_q[TX_W-1];
                tx_sh_d   = {tx_sh_q[TX_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
              end
            end
          endcase
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_phase_q <= PH_SHIFT;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
      rd_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_phase_q <= rd_phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      rd_flag_q  <= rd_flag_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb/tb_spi_slave_fsm.sv - directed bench for spi_slave_fsm with rx word and MISO bit scoreboards
module tb_spi_slave_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(10), .TX_W(8)) bus ();
  spi_slave_fsm #(.DATA_W(10), .TX_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [9:0] sb_q[$];
  logic       miso_exp[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs settle after each rising edge; sample 1 time unit later
  always @(posedge clk) begin
    logic [9:0] e;
    logic       m;
    #1;
    if (bus.rx_valid === 1'b1) begin
      if (sb_q.size() == 0) chk("rx_valid_spurious", 16'(bus.rx_valid), 16'h0);
      else begin
        e = sb_q.pop_front();
        chk("rx_data", 16'(bus.rx_data), 16'(e));
      end
    end
    m = (miso_exp.size() != 0) ? miso_exp.pop_front() : 1'b0;
    chk("miso", 16'(bus.MISO), 16'(m));
  end

  task automatic frame_start(input logic dir);
    @(negedge clk); bus.SS_n = 1'b0; bus.MOSI = 1'b0;
    @(negedge clk); bus.MOSI = dir;
  endtask

  task automatic send_bits(input logic [9:0] w, input int n, input int stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.MOSI     = w[9-i];
      bus.tx_valid = (i == stray);
      bus.tx_data  = 8'hFF;
    end
  endtask

  task automatic end_frame();
    @(negedge clk); bus.SS_n = 1'b1; bus.tx_valid = 1'b0; bus.MOSI = 1'b0;
  endtask

  task automatic full_frame(input logic dir, input logic [9:0] w, input int stray);
    frame_start(dir);
    sb_q.push_back(w);
    send_bits(w, 10, stray);
    end_frame();
  endtask

  task automatic read_data_frame(input logic [9:0] w, input logic [7:0] b);
    frame_start(1'b1);
    sb_q.push_back(w);
    send_bits(w, 10, -1);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    for (int i = 7; i >= 0; i--) miso_exp.push_back(b[i]);
    miso_exp.push_back(1'b0);
    @(negedge clk); bus.tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    bus.SS_n = 1'b1;
  endtask

  initial begin
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_miso", 16'(bus.MISO), 16'h0);
    chk("reset_rx_data", 16'(bus.rx_data), 16'h0);
    chk("reset_rx_valid", 16'(bus.rx_valid), 16'h0);
    rst = 1'b0;

    full_frame(1'b0, 10'h0A5, -1);
    full_frame(1'b0, 10'h13C, -1);

    // Abort a write after E7: no strobe, rx_data holds the last word
    frame_start(1'b0);
    send_bits(10'h2AA, 6, -1);
    end_frame();
    repeat (2) @(negedge clk);
    chk("abort_hold", 16'(bus.rx_data), 16'h13C);
    full_frame(1'b0, 10'h2F0, -1);

    // Reset asserted during E5 of a write frame
    frame_start(1'b0);
    send_bits(10'h155, 4, -1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_rx_data", 16'(bus.rx_data), 16'h0);
    chk("rst_mid_rx_valid", 16'(bus.rx_valid), 16'h0);
    chk("rst_mid_miso", 16'(bus.MISO), 16'h0);
    @(negedge clk); rst = 1'b0; bus.SS_n = 1'b1;
    full_frame(1'b0, 10'h1E1, -1);

    // Stray tx_valid inside a write frame and while idle
    full_frame(1'b0, 10'h099, 3);
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    repeat (3) @(negedge clk);
    bus.tx_valid = 1'b0;

    // Deselect on the same edge as the 10th bit: no strobe
    frame_start(1'b0);
    send_bits(10'h3FF, 9, -1);
    @(negedge clk); bus.MOSI = 1'b1; bus.SS_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("tenth_bit_hold", 16'(bus.rx_data), 16'h099);

    // Read address, then read data with the RAM answering 0xC3
    full_frame(1'b1, 10'h207, -1);
    read_data_frame(10'h300, 8'hC3);

    // Flag now cleared: a dir=1 frame is a read address, so a RAM reply is not shifted out
    frame_start(1'b1);
    sb_q.push_back(10'h0FF);
    send_bits(10'h0FF, 10, -1);
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'h81;
    @(negedge clk); bus.tx_valid = 1'b0;
    @(negedge clk); bus.SS_n = 1'b1;

    // Read data aborted while waiting for the RAM keeps the flag set
    frame_start(1'b1);
    sb_q.push_back(10'h311);
    send_bits(10'h311, 10, -1);
    repeat (4) @(negedge clk);
    bus.SS_n = 1'b1;
    read_data_frame(10'h322, 8'h5A);

    repeat (4) @(negedge clk);
    chk("final_rx_data", 16'(bus.rx_data), 16'h322);
    chk("sb_rx_drained", 16'(sb_q.size()), 16'h0);
    chk("sb_miso_drained", 16'(miso_exp.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
